sync_fifo_drain: RTL and testbench
==================================

# sync_fifo_drain

Parametrised synchronous FIFO that buffers DATA_W-bit words between a byte/word producer and the transmit path. It supports normal single-word reads and a burst "drain" mode: a rising edge on start_tx empties the FIFO one word per cycle without further read requests. It provides full/empty, programmable almost-full/almost-empty thresholds, an occupancy count and overflow/underflow error pulses.

## Interface
Parameters:
- DATA_W, 8, word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AFULL_TH, DEPTH-2, almost_full asserted when count ≥ AFULL_TH
- AEMPTY_TH, 2, almost_empty asserted when count ≤ AEMPTY_TH

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- wr_en  in  1  write request
- wr_data  in  DATA_W  write word
- rd_en  in  1  read request (honoured only in IDLE)
- start_tx  in  1  synchronous level; rising edge starts drain
- rd_data  out  DATA_W  registered read word
- rd_valid  out  1  rd_data valid this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_TH
- almost_empty  out  1  count ≤ AEMPTY_TH
- count  out  $clog2(DEPTH)+1  current occupancy
- busy  out  1  FSM in DRAIN
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Storage: DEPTH×DATA_W array; write/read pointers $clog2(DEPTH) bits, wrap modulo DEPTH naturally; count held explicitly.
- Write accepted when wr_en && (!full || pop this cycle). Otherwise overflow pulses, data dropped, pointer unchanged.
- Pop request: IDLE → rd_en; DRAIN → 1 every cycle. Pop accepted when !empty; rd_en while empty in IDLE pulses underflow. DRAIN never flags underflow.
- Write while empty is not bypassed: the word becomes readable the next cycle.
- count next = count + push − pop; simultaneous push and pop when full or mid-range leaves count unchanged.
- Edge detect: start_tx registered once; edge = start_tx & !start_tx_q.
- FSM IDLE: edge && !empty → DRAIN; edge while empty ignored.
- FSM DRAIN: pops every cycle; → IDLE in the cycle the pop takes count to 0 with no concurrent push. Writes during DRAIN are accepted and extend the drain. rd_en and further start_tx edges are ignored in DRAIN.
- Thresholds are compared against registered count; the flags are combinational from count.

## Timing
- Read latency 1: pop accepted in cycle N → rd_data/rd_valid in N+1. rd_data holds its last value when rd_valid=0.
- Drain: edge seen at cycle N (start_tx high at N, low at N−1) → busy=1 from N+1, first pop at N+1, first rd_valid at N+2, K words → K consecutive rd_valid cycles, busy falls the cycle after the last pop.
- Flags and count update on the clock edge following push/pop.
- Reset (async, any time, including mid-drain): pointers=0, count=0, FSM=IDLE, start_tx_q=0, rd_data=0, rd_valid=0, overflow=0, underflow=0, busy=0, empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not cleared. If start_tx is high at reset release, it counts as an edge on the first clock.

## Structure
- Shared package fifo_pkg: FSM state enum (ST_IDLE, ST_DRAIN), helper function for pointer width.
- One sub-module fifo_mem (simple dual-port array, 1 write port, 1 registered read port); control, FSM and flags in the top.

## Test plan
- Reset, write 0x01..0x10 (DEPTH=16) → full=1, count=16, almost_full from count 14; 17th write → overflow pulse, count stays 16.
- IDLE reads with rd_en → 0x01..0x10 in order, each one cycle after rd_en; extra rd_en at empty → underflow pulse, rd_valid=0.
- Load 5 words, pulse start_tx → busy for 5 cycles, 5 consecutive rd_valid, then IDLE, empty=1; rd_en held high during drain has no extra effect.
- Drain with writes injected mid-drain (3 loaded + 2 written) → 5 words out back-to-back, in order.
- Full FIFO, simultaneous wr_en+rd_en → no overflow, count stays 16; wrap-around across 40 mixed operations matches the scoreboard.
- Assert rst mid-drain → all outputs at reset values immediately; start_tx edge on empty FIFO → stays IDLE.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the drainable synchronous FIFO: FSM state encoding
// and the pointer-width helper used by the top and the storage array.
package fifo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Pointer width for a given depth; never collapses to zero bits.
  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port and one registered
// read port whose output holds its value when no read is requested.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = ptrWidth(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wrEn,
  input  logic [AW-1:0]     i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic              i_rdEn,
  input  logic [AW-1:0]     i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdData;

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  // A same-address write and read returns the old word, which is what a
  // simultaneous push/pop on a full FIFO needs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdData <= '0;
    end else if (i_rdEn) begin
      r_rdData <= r_mem[i_rdAddr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/sync_fifo_drain.sv
// Synchronous FIFO with single-word reads in IDLE and a burst drain mode
// started by a rising edge on start_tx; flags derive from the registered count.
module sync_fifo_drain
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              start_tx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CW-1:0]     count,
  output logic              busy,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = ptrWidth(DEPTH);
  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  state_t        r_state;
  state_t        w_stateNext;
  logic          r_startQ;
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_rdValid;
  logic          r_overflow;
  logic          r_underflow;

  logic w_edge;
  logic w_popReq;
  logic w_pop;
  logic w_push;
  logic w_full;
  logic w_empty;

  assign w_full   = (r_count == FULL_C);
  assign w_empty  = (r_count == '0);
  assign w_edge   = start_tx & ~r_startQ;
  assign w_popReq = (r_state == ST_DRAIN) ? 1'b1 : rd_en;
  assign w_pop    = w_popReq & ~w_empty;
  assign w_push   = wr_en & (~w_full | w_pop);

  // Next state: leave DRAIN only when this pop empties the FIFO and no
  // concurrent write refills it.
  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_edge && !w_empty) begin
          w_stateNext = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_pop && !w_push && (r_count == CW'(1))) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_startQ <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_startQ <= start_tx;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Error pulses; drain pops are never counted as rejected reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdValid   <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rdValid   <= w_pop;
      r_overflow  <= wr_en & ~w_push;
      r_underflow <= (r_state == ST_IDLE) & rd_en & w_empty;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .i_wrEn   (w_push),
    .i_wrAddr (r_wrPtr),
    .i_wrData (wr_data),
    .i_rdEn   (w_pop),
    .i_rdAddr (r_rdPtr),
    .o_rdData (rd_data)
  );

  assign rd_valid     = r_rdValid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AFULL_C);
  assign almost_empty = (r_count <= AEMPTY_C);
  assign count        = r_count;
  assign busy         = (r_state == ST_DRAIN);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_drain.sv
// Directed bench for sync_fifo_drain: a table of single-cycle vectors, then
// hand-written fill, read, drain, wrap-around and reset sequences.
module tb_sync_fifo_drain;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              start_tx;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              busy;
  logic              overflow;
  logic              underflow;

  int total = 0;
  int bad   = 0;
  logic [7:0] lastData;

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       st;
    logic       eValid;
    logic [7:0] eData;
    int         eCount;
    logic       eUnf;
  } vec_t;

  vec_t vecs[12];

  sync_fifo_drain #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_TH  (DEPTH - 2),
    .AEMPTY_TH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .start_tx     (start_tx),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .busy         (busy),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flags are derived from the expected occupancy with the bench thresholds.
  task automatic checkAll(input string tag, input logic eValid, input logic [7:0] eData,
                          input int eCount, input logic eBusy, input logic eOvf, input logic eUnf);
    checkOutput({tag, ".rd_valid"}, 32'(rd_valid), 32'(eValid));
    checkOutput({tag, ".rd_data"}, 32'(rd_data), 32'(eData));
    checkOutput({tag, ".count"}, 32'(count), 32'(eCount));
    checkOutput({tag, ".full"}, 32'(full), 32'(eCount == DEPTH));
    checkOutput({tag, ".empty"}, 32'(empty), 32'(eCount == 0));
    checkOutput({tag, ".almost_full"}, 32'(almost_full), 32'(eCount >= DEPTH - 2));
    checkOutput({tag, ".almost_empty"}, 32'(almost_empty), 32'(eCount <= 2));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(eBusy));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(eOvf));
    checkOutput({tag, ".underflow"}, 32'(underflow), 32'(eUnf));
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic wr, input logic [7:0] wd, input logic rd, input logic st);
    wr_en    = wr;
    wr_data  = wd;
    rd_en    = rd;
    start_tx = st;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst      = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    rd_en    = 1'b0;
    start_tx = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b1;
    lastData = 8'h00;
  endtask

  initial begin
    logic [7:0] q[$];
    logic       wr, rd, popped, pushed, eOvf, eUnf;
    int         sizeBefore;

    rst      = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    rd_en    = 1'b0;
    start_tx = 1'b0;
    lastData = 8'h00;
    #2;
    checkAll("reset", 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    //            wr    wd     rd    st    valid data  cnt unf
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1};
    vecs[1]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0};
    vecs[2]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b0};
    vecs[3]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 8'hA1, 2, 1'b0};
    vecs[4]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 8'hA1, 3, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA2, 2, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA3, 1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA4, 0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA4, 0, 1'b1};
    vecs[9]  = '{1'b1, 8'hB5, 1'b1, 1'b0, 1'b0, 8'hA4, 1, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB5, 0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hB5, 0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].st);
      checkAll($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].eData, vecs[i].eCount,
               1'b0, 1'b0, vecs[i].eUnf);
    end
    lastData = 8'hB5;

    // Fill to full, then one rejected write.
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      checkAll($sformatf("fill%0d", i), 1'b0, lastData, i, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    checkAll("overflow", 1'b0, lastData, DEPTH, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkAll("overflow_clear", 1'b0, lastData, DEPTH, 1'b0, 1'b0, 1'b0);

    // Single reads return 0x01..0x10 in order, then an underflow.
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkAll($sformatf("read%0d", i), 1'b1, 8'(i), DEPTH - i, 1'b0, 1'b0, 1'b0);
    end
    lastData = 8'h10;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkAll("underflow", 1'b0, lastData, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Drain of 5 words with rd_en held and a stray start_tx edge mid-drain.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkAll("drainA_start", 1'b0, lastData, 5, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, k == 2);
      checkAll($sformatf("drainA%0d", k), 1'b1, 8'(8'h20 + k - 1), 5 - k, k < 5, 1'b0, 1'b0);
    end
    lastData = 8'h24;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkAll("drainA_end", 1'b0, lastData, 0, 1'b0, 1'b0, 1'b0);

    // Drain of 3 loaded words extended by 2 writes during the drain.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkAll("drainB_start", 1'b0, lastData, 3, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(k <= 2, 8'(8'h32 + k), 1'b0, 1'b0);
      checkAll($sformatf("drainB%0d", k), 1'b1, 8'(8'h30 + k - 1),
               (k <= 2) ? 3 : 5 - k, k < 5, 1'b0, 1'b0);
    end
    lastData = 8'h34;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkAll("drainB_end", 1'b0, lastData, 0, 1'b0, 1'b0, 1'b0);

    // Full FIFO with simultaneous write and read, then mixed wrap-around traffic.
    q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
      q.push_back(8'(8'h50 + i));
    end
    applyStimulus(1'b1, 8'h60, 1'b1, 1'b0);
    lastData = q.pop_front();
    q.push_back(8'h60);
    checkAll("full_wr_rd", 1'b1, lastData, DEPTH, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      wr         = (i % 3) != 0;
      rd         = (i % 4) != 3;
      sizeBefore = q.size();
      popped     = rd && (sizeBefore > 0);
      pushed     = wr && ((sizeBefore < DEPTH) || popped);
      eOvf       = wr && !pushed;
      eUnf       = rd && (sizeBefore == 0);
      applyStimulus(wr, 8'(8'h80 + i), rd, 1'b0);
      if (popped) lastData = q.pop_front();
      if (pushed) q.push_back(8'(8'h80 + i));
      checkAll($sformatf("mix%0d", i), popped, lastData, q.size(), 1'b0, eOvf, eUnf);
    end

    // Asynchronous reset in the middle of a drain.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkAll("drainC_start", 1'b0, 8'h00, 4, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkAll("drainC1", 1'b1, 8'h70, 3, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkAll("async_reset", 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkAll("reset_held", 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);

    // start_tx high at release is an edge, but the FIFO is empty.
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkAll("edge_empty1", 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkAll("edge_empty2", 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkAll("edge_empty3", 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
